// File: rtl/pad_ai_if.sv
// Ball-logic <-> paddle AI link.
// The ball logic (master) publishes the motion strobe, game state and ball
// position. The AI controller (slave) returns the right paddle position.
interface pad_ai_if;
    logic        timing_tick;
    logic [1:0]  state;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [9:0]  y_pad_right;
    logic        pad_moving;

    modport master (
        output timing_tick, state, x_ball, y_ball,
        input  y_pad_right, pad_moving
    );

    modport slave (
        input  timing_tick, state, x_ball, y_ball,
        output y_pad_right, pad_moving
    );
endinterface

// File: rtl/pad_ai_controller.sv
// pad_ai_controller: computer opponent driving the right paddle.
// Tracks the ball at a bounded speed, after a reaction delay and with a dead
// zone, so that it can be beaten. Everything advances on timing_tick, except
// that leaving the play state recentres the paddle on the very next clock.
// Optional feature: define AI_MISS_EN to add an LFSR that occasionally makes
// the paddle aim a full paddle height away from the ball for a whole rally.
module pad_ai_controller #(
    parameter int         VER_PIXELS  = 768,
    parameter int         PAD_HEIGHT  = 145,
    parameter int         BALL_SIZE   = 15,
    parameter int         PAD_SPEED   = 2,
    parameter int         DEAD_ZONE   = 4,
    parameter int         REACT_X     = 512,
    parameter int         REACT_DELAY = 8,
    parameter logic [1:0] PLAY_STATE  = 2'b01
) (
    input  logic     clk,
    input  logic     rst,
    pad_ai_if.slave  pif
);

    localparam logic signed [11:0] Y_MAX      = 12'(VER_PIXELS - PAD_HEIGHT);
    localparam logic signed [11:0] Y_CENTRE   = 12'((VER_PIXELS - PAD_HEIGHT) / 2);
    localparam logic [9:0]         Y_CENTRE_P = 10'((VER_PIXELS - PAD_HEIGHT) / 2);
    localparam logic signed [11:0] AIM_OFS    = 12'(BALL_SIZE / 2 - PAD_HEIGHT / 2);
    localparam logic signed [11:0] MISS_OFS   = 12'(PAD_HEIGHT);
    localparam logic signed [11:0] DZ         = 12'(DEAD_ZONE);
    localparam logic signed [11:0] SPD        = 12'(PAD_SPEED);
    localparam logic [10:0]        REACT_XV   = 11'(REACT_X);
    localparam logic [9:0]         HALF_SCR   = 10'(VER_PIXELS / 2);
    localparam logic [7:0]         DELAY_LOAD = 8'(REACT_DELAY);

    typedef enum logic [1:0] {S_IDLE, S_RETURN, S_REACT, S_TRACK} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [9:0]         y_q, y_d;
    logic               moving_q, moving_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [10:0]        x_prev_q;
    logic               miss_q, miss_d;
    logic               miss_hit;
    logic               load;
    logic               ball_right;
    logic               in_zone;
    logic signed [11:0] miss_ofs;
    logic signed [11:0] ball_tgt;
    logic [10:0]        centre_step;
    logic [10:0]        ball_step;

    function automatic logic signed [11:0] clamp_y(input logic signed [11:0] v);
        if (v < 12'sd0)
            return 12'sd0;
        else if (v > Y_MAX)
            return Y_MAX;
        return v;
    endfunction

    // Returns {moved, new_y}: one bounded step toward tgt, never overshooting.
    function automatic logic [10:0] step_toward(input logic signed [11:0] tgt,
                                                input logic [9:0] cur);
        logic signed [11:0] cur_s;
        logic signed [11:0] diff;
        logic signed [11:0] mag;
        logic signed [11:0] step;
        logic signed [11:0] res;
        cur_s = $signed({2'b00, cur});
        diff  = tgt - cur_s;
        mag   = (diff < 12'sd0) ? -diff : diff;
        if (mag <= DZ)
            return {1'b0, cur};
        step = (mag < SPD) ? mag : SPD;
        res  = clamp_y((diff < 12'sd0) ? (cur_s - step) : (cur_s + step));
        return {1'b1, res[9:0]};
    endfunction

    assign ball_right  = pif.x_ball > x_prev_q;
    assign in_zone     = pif.x_ball >= REACT_XV;
    assign miss_ofs    = !miss_q ? 12'sd0 :
                         (pif.y_ball < HALF_SCR) ? MISS_OFS : -MISS_OFS;
    assign ball_tgt    = clamp_y($signed({2'b00, pif.y_ball}) + AIM_OFS + miss_ofs);
    assign centre_step = step_toward(Y_CENTRE, y_q);
    assign ball_step   = step_toward(ball_tgt, y_q);

`ifdef AI_MISS_EN
    logic [7:0] lfsr_q;

    assign miss_hit = (lfsr_q[1:0] == 2'b00);

    // Free-running Fibonacci LFSR (taps 8,6,5,4), stepped once per tick in play.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr_q <= 8'hA5;
        else if (pif.timing_tick && pif.state == PLAY_STATE)
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
`else
    assign miss_hit = 1'b0;
`endif

    // Next-state and paddle update; leaving play overrides everything, any cycle.
    always_comb begin
        fsm_d    = fsm_q;
        y_d      = y_q;
        moving_d = moving_q;
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        load     = 1'b0;
        if (pif.state != PLAY_STATE) begin
            load     = 1'b1;
            fsm_d    = S_IDLE;
            y_d      = Y_CENTRE_P;
            moving_d = 1'b0;
            miss_d   = 1'b0;
        end else if (pif.timing_tick) begin
            load = 1'b1;
            case (fsm_q)
                S_IDLE: begin
                    fsm_d    = S_RETURN;
                    y_d      = Y_CENTRE_P;
                    moving_d = 1'b0;
                    miss_d   = 1'b0;
                end
                S_RETURN: begin
                    {moving_d, y_d} = centre_step;
                    if (ball_right && in_zone) begin
                        cnt_d  = DELAY_LOAD;
                        fsm_d  = (REACT_DELAY == 0) ? S_TRACK : S_REACT;
                        miss_d = miss_hit;
                    end
                end
                S_REACT: begin
                    moving_d = 1'b0;
                    if (!ball_right) begin
                        fsm_d  = S_RETURN;
                        miss_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1)
                            fsm_d = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (!ball_right || !in_zone) begin
                        fsm_d           = S_RETURN;
                        miss_d          = 1'b0;
                        {moving_d, y_d} = centre_step;
                    end else begin
                        {moving_d, y_d} = ball_step;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    // State register; x_prev follows the ball on every tick whatever the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= S_IDLE;
            y_q      <= Y_CENTRE_P;
            moving_q <= 1'b0;
            cnt_q    <= 8'd0;
            miss_q   <= 1'b0;
            x_prev_q <= 11'd0;
        end else begin
            if (pif.timing_tick)
                x_prev_q <= pif.x_ball;
            if (load) begin
                fsm_q    <= fsm_d;
                y_q      <= y_d;
                moving_q <= moving_d;
                cnt_q    <= cnt_d;
                miss_q   <= miss_d;
            end
        end
    end

    assign pif.y_pad_right = y_q;
    assign pif.pad_moving  = moving_q;

endmodule
